// File: rtl/fdivsqrt_seq_ctrl.sv
// Sequencing controller for the iterative FP divide/sqrt and integer divide unit.
// Accepts one request, runs a step down-counter, and holds the result until Memory takes it.
module fdivsqrt_seq_ctrl #(
    parameter int DURLEN    = 6,
    parameter bit EARLYTERM = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FDivStartE,
    input  logic              IDivStartE,
    input  logic              StallE,
    input  logic              StallM,
    input  logic              FlushE,
    input  logic              SpecialCaseE,
    input  logic [DURLEN-1:0] CyclesE,
    input  logic              WZeroE,
    output logic              IFDivStartE,
    output logic              IterEnE,
    output logic              FDivBusyE,
    output logic              FDivDoneE,
    output logic              SpecialCaseHeld
);

    // state | meaning
    // IDLE  | waiting for a start request; Step is 0
    // BUSY  | iterating; Step counts remaining iterations down to 1
    // DONE  | result valid; held here while Memory stalls
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DURLEN-1:0] step_q, step_d;
    logic              held_q, held_d;
    logic [DURLEN-1:0] cycles_sat;
    logic              accept;
    logic              term;

    // A zero iteration count still takes one BUSY cycle so the datapath sees a load and a step.
    assign cycles_sat = (CyclesE == '0) ? DURLEN'(1) : CyclesE;

    // Gating with reset keeps the start pulse low while the block is held in reset.
    assign accept = reset & (state_q == IDLE) & (FDivStartE | IDivStartE) & ~StallE & ~FlushE;
    assign term   = (step_q == DURLEN'(1)) | (EARLYTERM & WZeroE);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        held_d  = held_q;
        if (FlushE) begin
            state_d = IDLE;
            step_d  = '0;
            held_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    step_d = '0;
                    if (accept) begin
                        held_d = SpecialCaseE;
                        if (SpecialCaseE) begin
                            state_d = DONE;
                        end else begin
                            state_d = BUSY;
                            step_d  = cycles_sat;
                        end
                    end
                end
                BUSY: begin
                    if (term) begin
                        state_d = DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q - DURLEN'(1);
                    end
                end
                DONE: begin
                    step_d = '0;
                    if (!StallM) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                    held_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            held_q  <= held_d;
        end
    end

    assign IFDivStartE     = accept;
    assign IterEnE         = (state_q == BUSY);
    assign FDivDoneE       = (state_q == DONE);
    assign FDivBusyE       = (state_q == BUSY) | ((state_q == DONE) & StallM);
    assign SpecialCaseHeld = held_q;

endmodule

// File: tb/tb_fdivsqrt_seq_ctrl.sv
// Randomized bench for fdivsqrt_seq_ctrl; expected outputs come from a per-operation
// timeline model (done cycle and stall window computed arithmetically).
module tb_fdivsqrt_seq_ctrl;
    localparam int DURLEN = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              FDivStartE, IDivStartE, StallE, StallM, FlushE, SpecialCaseE, WZeroE;
    logic [DURLEN-1:0] CyclesE;
    logic              IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, SpecialCaseHeld;

    int passed = 0;
    int total  = 0;

    fdivsqrt_seq_ctrl #(.DURLEN(DURLEN), .EARLYTERM(1'b1)) dut (
        .clk(clk), .reset(reset),
        .FDivStartE(FDivStartE), .IDivStartE(IDivStartE),
        .StallE(StallE), .StallM(StallM), .FlushE(FlushE),
        .SpecialCaseE(SpecialCaseE), .CyclesE(CyclesE), .WZeroE(WZeroE),
        .IFDivStartE(IFDivStartE), .IterEnE(IterEnE), .FDivBusyE(FDivBusyE),
        .FDivDoneE(FDivDoneE), .SpecialCaseHeld(SpecialCaseHeld)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {IFDivStartE, IterEnE, FDivBusyE, FDivDoneE};
    endfunction

    task automatic idle_inputs();
        FDivStartE = 0; IDivStartE = 0; StallE = 0; StallM = 0;
        FlushE = 0; SpecialCaseE = 0; WZeroE = 0; CyclesE = '0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset = 0;
        idle_inputs();
        FDivStartE = 1; CyclesE = 6'd4;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        got = outs();
        total++;
        if (got !== 4'b0000 || SpecialCaseHeld !== 1'b0)
            $display("FAIL reset_outputs got=%b held=%b exp=0000 held=0", got, SpecialCaseHeld);
        else passed++;
        @(negedge clk);
        idle_inputs();
        reset = 1;
    endtask

    // One operation: n = CyclesE, wz = BUSY cycle with WZeroE (0 = none), stall = DONE stall cycles.
    task automatic run_op(input int n, input bit special, input int wz, input int stall, input bit idiv,
                          input string name);
        int nn, done_at, last;
        logic [3:0] exp, got;
        logic e_start, e_iter, e_busy, e_done, active;
        nn      = (n == 0) ? 1 : n;
        done_at = special ? 1 : ((wz >= 1 && wz <= nn) ? wz + 1 : nn + 1);
        last    = done_at + stall + 1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            active       = (c >= 1) && (c <= done_at + stall);
            FDivStartE   = (c == 0) ? !idiv : (active ? 1'($urandom) : 1'b0);
            IDivStartE   = (c == 0) ? idiv  : (active ? 1'($urandom) : 1'b0);
            CyclesE      = (c == 0) ? DURLEN'(n) : DURLEN'($urandom);
            SpecialCaseE = (c == 0) ? special : 1'($urandom);
            StallE       = active ? 1'($urandom) : 1'b0;
            FlushE       = 0;
            if (c >= done_at) StallM = (c < done_at + stall);
            else              StallM = 1'($urandom);
            if (!special && c >= 1 && c < done_at) WZeroE = (c == wz);
            else                                   WZeroE = 1'($urandom);
            #1;
            e_start = (c == 0);
            e_iter  = !special && c >= 1 && c < done_at;
            e_done  = c >= done_at && c <= done_at + stall;
            e_busy  = e_iter || (e_done && c < done_at + stall);
            exp     = {e_start, e_iter, e_busy, e_done};
            got     = outs();
            total++;
            if (got !== exp)
                $display("FAIL %s cyc%0d {start,iter,busy,done} got=%b exp=%b", name, c, got, exp);
            else passed++;
            if (c == done_at) begin
                total++;
                if (SpecialCaseHeld !== special)
                    $display("FAIL %s held got=%b exp=%b", name, SpecialCaseHeld, special);
                else passed++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_directed();
        run_op(5, 0, 0, 0, 0, "normal_c5");
        run_op(20, 0, 3, 0, 0, "early_c20_wz3");
        run_op(9, 1, 0, 0, 1, "special_idiv");
        run_op(4, 0, 0, 3, 0, "stall3");
        run_op(0, 0, 0, 0, 0, "cycles0");
        run_op(6, 0, 6, 0, 0, "wz_at_last_step");
        run_op(63, 0, 0, 1, 1, "cycles_max");
    endtask

    task automatic test_random();
        int n, wz, st;
        bit sp;
        for (int i = 0; i < 30; i++) begin
            n  = $urandom_range(0, 40);
            sp = ($urandom_range(0, 4) == 0);
            wz = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 45) : 0;
            st = $urandom_range(0, 4);
            run_op(n, sp, wz, st, 1'($urandom), "random");
        end
    endtask

    task automatic test_flush();
        int nn, k;
        logic [3:0] exp, got;
        nn = $urandom_range(4, 20);
        k  = nn - 2;   // BUSY cycle whose Step is 3
        for (int c = 0; c <= k + 5; c++) begin
            @(negedge clk);
            FDivStartE = (c == 0) || (c == k) || (c == k + 2);
            CyclesE    = DURLEN'(nn);
            FlushE     = (c == k) || (c == k + 2);
            #1;
            exp = {(c == 0), (c >= 1 && c <= k), (c >= 1 && c <= k), 1'b0};
            got = outs();
            total++;
            if (got !== exp)
                $display("FAIL flush cyc%0d {start,iter,busy,done} got=%b exp=%b", c, got, exp);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        logic [3:0] got;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            FDivStartE = (c == 0);
            CyclesE    = 6'd10;
        end
        #1;
        total++;
        if (IterEnE !== 1'b1) $display("FAIL async_pre_busy iter got=%b exp=1", IterEnE);
        else passed++;
        #2 reset = 0;
        FDivStartE = 1;
        #1;
        got = outs();
        total++;
        if (got !== 4'b0000 || SpecialCaseHeld !== 1'b0)
            $display("FAIL async_reset_outputs got=%b held=%b exp=0000 held=0", got, SpecialCaseHeld);
        else passed++;
        idle_inputs();
        @(negedge clk);
        reset = 1;
        run_op(2, 0, 0, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_random();
        test_async_reset();
        run_op(3, 1, 0, 2, 0, "back_to_back_a");
        run_op(7, 0, 2, 0, 1, "back_to_back_b");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
